// File: rtl/sram_line_ctrl_if.sv
// Cache-side and SRAM-side signals of the line controller.
// The controller uses the slave modport; the caches and SRAM together use the master modport.
interface sram_line_ctrl_if #(
  parameter int ADDR_W     = 20,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = 32 * LINE_WORDS;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_ready;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_ready;

  logic [ADDR_W-1:0] sram_a;
  logic [31:0]       sram_d;
  logic              sram_we_n;
  logic              sram_csb;
  logic [31:0]       sram_q;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, sram_q,
    output ic_rdata, ic_ready, dc_rdata, dc_ready,
           sram_a, sram_d, sram_we_n, sram_csb
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, sram_q,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready,
           sram_a, sram_d, sram_we_n, sram_csb
  );
endinterface

// File: rtl/sram_line_ctrl.sv
// Arbitrates ic/dc line requests and serialises each line into LINE_WORDS
// 32-bit accesses on a single-port SRAM with one-cycle registered read data.
module sram_line_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int LINE_WORDS = 4
) (
  input  logic clk,
  input  logic rst_n,
  sram_line_ctrl_if.slave bus
);
  localparam int OW     = $clog2(LINE_WORDS);
  localparam int HW     = ADDR_W - OW;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

  state_t            state, state_next;
  logic [OW-1:0]     cnt, cnt_inc, cap_idx;
  logic [HW-1:0]     base_hi, req_hi;
  logic [LINE_W-1:0] wdata_q;
  logic              sel_dc, last_dc;
  logic              accept, grant_dc, grant_wr, capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // On contention the port that did not win last time is granted (last_dc=0 means ic won last).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    grant_dc   = bus.dc_req && (!bus.ic_req || !last_dc);
    grant_wr   = grant_dc && bus.dc_we;
    req_hi     = grant_dc ? bus.dc_addr[ADDR_W-1:OW] : bus.ic_addr[ADDR_W-1:OW];
    cnt_inc    = cnt + OW'(1);
    cap_idx    = (state == RD_TAIL) ? cnt : cnt - OW'(1);
    capture    = (state == RD_TAIL) || ((state == RD) && (cnt != '0));
    case (state)
      IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          accept     = 1'b1;
          state_next = grant_wr ? WR : RD;
        end
      end
      RD:      if (cnt == LAST) state_next = RD_TAIL;
      RD_TAIL: state_next = DONE;
      WR:      if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Offsets only fill the low OW address bits, so a line never carries or wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      base_hi       <= '0;
      wdata_q       <= '0;
      sel_dc        <= 1'b0;
      last_dc       <= 1'b0;
      bus.sram_a    <= '0;
      bus.sram_d    <= '0;
      bus.sram_we_n <= 1'b1;
      bus.sram_csb  <= 1'b1;
      bus.ic_ready  <= 1'b0;
      bus.dc_ready  <= 1'b0;
      bus.ic_rdata  <= '0;
      bus.dc_rdata  <= '0;
    end else begin
      bus.ic_ready <= 1'b0;
      bus.dc_ready <= 1'b0;

      // Read data lags the address by one cycle, hence word cap_idx trails cnt.
      if (capture) begin
        if (sel_dc) bus.dc_rdata[32*int'(cap_idx) +: 32] <= bus.sram_q;
        else        bus.ic_rdata[32*int'(cap_idx) +: 32] <= bus.sram_q;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            base_hi       <= req_hi;
            sel_dc        <= grant_dc;
            last_dc       <= grant_dc;
            wdata_q       <= bus.dc_wdata;
            cnt           <= '0;
            bus.sram_a    <= {req_hi, OW'(0)};
            bus.sram_csb  <= 1'b0;
            bus.sram_we_n <= !grant_wr;
            if (grant_wr) bus.sram_d <= bus.dc_wdata[31:0];
          end
        end
        RD: begin
          if (cnt != LAST) begin
            cnt        <= cnt_inc;
            bus.sram_a <= {base_hi, cnt_inc};
          end else begin
            bus.sram_csb <= 1'b1;
          end
        end
        RD_TAIL: begin
          if (sel_dc) bus.dc_ready <= 1'b1;
          else        bus.ic_ready <= 1'b1;
        end
        WR: begin
          if (cnt != LAST) begin
            cnt        <= cnt_inc;
            bus.sram_a <= {base_hi, cnt_inc};
            bus.sram_d <= wdata_q[32*int'(cnt_inc) +: 32];
          end else begin
            bus.sram_csb  <= 1'b1;
            bus.sram_we_n <= 1'b1;
            bus.dc_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_line_ctrl.sv
// Directed bench for sram_line_ctrl: behavioural SRAM plus hand-computed expected lines and timing.
module tb_sram_line_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  sram_line_ctrl_if bus ();

  sram_line_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<20)-1];

  // Single-port SRAM with registered read data.
  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_we_n) mem[bus.sram_a] <= bus.sram_d;
      else                bus.sram_q      <= mem[bus.sram_a];
    end
  end

  localparam logic [127:0] LINE_A   = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] LINE_TOP = 128'hF0000003_F0000002_F0000001_F0000000;
  localparam logic [127:0] LINE_W1  = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
  localparam logic [127:0] LINE_W2  = 128'h44444444_33333333_22222222_11111111;

  int checksTotal  = 0;
  int checksPassed = 0;
  logic [127:0] icHeld, dcHeld;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit icReq, input logic [19:0] icAddr,
                               input bit dcReq, input bit dcWe,
                               input logic [19:0] dcAddr, input logic [127:0] dcWdata);
    bus.ic_req   = icReq;
    bus.ic_addr  = icAddr;
    bus.dc_req   = dcReq;
    bus.dc_we    = dcWe;
    bus.dc_addr  = dcAddr;
    bus.dc_wdata = dcWdata;
  endtask

  task automatic runRead(input bit isDc, input logic [19:0] addr, input logic [127:0] expLine);
    logic [19:0] base;
    base = addr & 20'hFFFFC;
    if (isDc) applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, addr, 128'h0);
    else      applyStimulus(1'b1, addr, 1'b0, 1'b0, 20'h0, 128'h0);
    waitCycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput("rd_addr", bus.sram_a, base + 20'(k));
      checkOutput("rd_csb", bus.sram_csb, 1'b0);
      checkOutput("rd_we_n", bus.sram_we_n, 1'b1);
      checkOutput("rd_early_ready", isDc ? bus.dc_ready : bus.ic_ready, 1'b0);
      waitCycle();
    end
    checkOutput("rd_tail_csb", bus.sram_csb, 1'b1);
    checkOutput("rd_tail_ready", isDc ? bus.dc_ready : bus.ic_ready, 1'b0);
    waitCycle();
    checkOutput("rd_ready", isDc ? bus.dc_ready : bus.ic_ready, 1'b1);
    checkOutput("rd_other_ready", isDc ? bus.ic_ready : bus.dc_ready, 1'b0);
    checkOutput("rd_line", isDc ? bus.dc_rdata : bus.ic_rdata, expLine);
    checkOutput("rd_other_line", isDc ? bus.ic_rdata : bus.dc_rdata, isDc ? icHeld : dcHeld);
    if (isDc) dcHeld = expLine;
    else      icHeld = expLine;
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 128'h0);
    waitCycle();
    checkOutput("rd_ready_drop", isDc ? bus.dc_ready : bus.ic_ready, 1'b0);
    checkOutput("rd_line_hold", isDc ? bus.dc_rdata : bus.ic_rdata, expLine);
  endtask

  task automatic runWrite(input logic [19:0] addr, input logic [127:0] line, input bit scramble);
    logic [19:0] base;
    base = addr & 20'hFFFFC;
    applyStimulus(1'b0, 20'h0, 1'b1, 1'b1, addr, line);
    waitCycle();
    for (int k = 0; k < 4; k++) begin
      if (scramble && k == 1) applyStimulus(1'b0, 20'h0, 1'b1, 1'b0, 20'h55555, ~line);
      checkOutput("wr_addr", bus.sram_a, base + 20'(k));
      checkOutput("wr_data", bus.sram_d, line[32*k +: 32]);
      checkOutput("wr_we_n", bus.sram_we_n, 1'b0);
      checkOutput("wr_csb", bus.sram_csb, 1'b0);
      checkOutput("wr_early_ready", bus.dc_ready, 1'b0);
      waitCycle();
    end
    checkOutput("wr_ready", bus.dc_ready, 1'b1);
    checkOutput("wr_ic_ready", bus.ic_ready, 1'b0);
    checkOutput("wr_done_we_n", bus.sram_we_n, 1'b1);
    checkOutput("wr_done_csb", bus.sram_csb, 1'b1);
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 128'h0);
    waitCycle();
    checkOutput("wr_ready_drop", bus.dc_ready, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 128'h0);
    mem[20'h00100] = 32'hA0000000;
    mem[20'h00101] = 32'hA0000001;
    mem[20'h00102] = 32'hA0000002;
    mem[20'h00103] = 32'hA0000003;
    mem[20'hFFFFC] = 32'hF0000000;
    mem[20'hFFFFD] = 32'hF0000001;
    mem[20'hFFFFE] = 32'hF0000002;
    mem[20'hFFFFF] = 32'hF0000003;
    mem[20'h00000] = 32'hDEAD0000;
    icHeld = '0;
    dcHeld = '0;
    waitCycle();
    waitCycle();

    checkOutput("rst_sram_a", bus.sram_a, 20'h0);
    checkOutput("rst_sram_d", bus.sram_d, 32'h0);
    checkOutput("rst_we_n", bus.sram_we_n, 1'b1);
    checkOutput("rst_csb", bus.sram_csb, 1'b1);
    checkOutput("rst_ic_ready", bus.ic_ready, 1'b0);
    checkOutput("rst_dc_ready", bus.dc_ready, 1'b0);
    checkOutput("rst_ic_rdata", bus.ic_rdata, 128'h0);
    checkOutput("rst_dc_rdata", bus.dc_rdata, 128'h0);
    rst_n = 1'b1;
    waitCycle();

    $display("[TB] ic read of line 0x100 via unaligned address 0x102");
    runRead(1'b0, 20'h00102, LINE_A);

    $display("[TB] dc write then read back at 0x2C");
    runWrite(20'h0002C, LINE_W1, 1'b0);
    runRead(1'b1, 20'h0002C, LINE_W1);

    $display("[TB] top-of-memory read");
    runRead(1'b0, 20'hFFFFF, LINE_TOP);

    $display("[TB] inputs changed mid-write");
    runWrite(20'h0002C, LINE_W2, 1'b1);
    runRead(1'b1, 20'h0002C, LINE_W2);

    $display("[TB] reset in the middle of a read");
    applyStimulus(1'b1, 20'h00100, 1'b0, 1'b0, 20'h0, 128'h0);
    waitCycle();
    waitCycle();
    waitCycle();
    rst_n = 1'b0;
    applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 128'h0);
    #1;
    checkOutput("midrst_csb", bus.sram_csb, 1'b1);
    checkOutput("midrst_sram_a", bus.sram_a, 20'h0);
    checkOutput("midrst_ic_rdata", bus.ic_rdata, 128'h0);
    checkOutput("midrst_dc_rdata", bus.dc_rdata, 128'h0);
    checkOutput("midrst_ic_ready", bus.ic_ready, 1'b0);
    icHeld = '0;
    dcHeld = '0;
    waitCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      waitCycle();
      checkOutput("postrst_ready", bus.ic_ready, 1'b0);
      checkOutput("postrst_csb", bus.sram_csb, 1'b1);
    end
    runRead(1'b0, 20'h00100, LINE_A);

    $display("[TB] contention right after reset");
    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    waitCycle();
    applyStimulus(1'b1, 20'h00100, 1'b1, 1'b0, 20'h0002C, 128'h0);
    for (int c = 1; c <= 28; c++) begin
      waitCycle();
      checkOutput("arb_dc_ready", bus.dc_ready, (c == 6 || c == 20));
      checkOutput("arb_ic_ready", bus.ic_ready, (c == 13 || c == 27));
      if (c == 1 || c == 15) checkOutput("arb_dc_addr", bus.sram_a, 20'h0002C);
      if (c == 8 || c == 22) checkOutput("arb_ic_addr", bus.sram_a, 20'h00100);
      if (c == 6 || c == 20) checkOutput("arb_dc_line", bus.dc_rdata, LINE_W2);
      if (c == 13 || c == 27) checkOutput("arb_ic_line", bus.ic_rdata, LINE_A);
      if (c == 27) applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 128'h0);
    end
    waitCycle();
    waitCycle();
    checkOutput("arb_idle_csb", bus.sram_csb, 1'b1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end
endmodule
